// File: rtl/seg7_mux_display.sv
// Multiplexed 7-segment hex driver: time-slices NUM_DIGITS digits, SCAN_DIV cycles per slot.
// Latency: a loaded value reaches the display at the next frame boundary (<= NUM_DIGITS*SCAN_DIV cycles).
// Backpressure: none; a newer load overwrites the waiting one. Optional SEG7_LEADING_ZERO_BLANK_EN.
module seg7_mux_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    pending,
    output logic                    frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] display;
    logic                    slot_end;
    logic [3:0]              nib;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign slot_end   = (presc == PRESC_LAST);
    assign frame_tick = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc   <= '0;
            idx     <= '0;
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
        end else begin
            presc <= slot_end ? '0 : presc + PW'(1);
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
            // display swaps only at frame end so a frame is never split
            if (frame_tick && pending) begin
                display <= shadow;
            end
            // a load on the tick cycle keeps pending set for the value it just wrote
            if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end else if (frame_tick) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        nib    = 4'h0;
        dig_en = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib = display[4*i +: 4];
            end
            // presc==0 leaves every digit off to hide ghosting during the switch
            dig_en[i] = (idx == IW'(i)) && (presc != '0);
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic upper_nz;

    always_comb begin
        upper_nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IW'(i) >= idx) && (display[4*i +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
    end

    assign seg = ((idx != '0) && !upper_nz) ? 7'h00 : hex7(nib);
`else
    assign seg = hex7(nib);
`endif

endmodule

// File: tb/tb_seg7_mux_display.sv
// Scoreboard bench for seg7_mux_display at NUM_DIGITS=4, SCAN_DIV=4 (16-cycle frame).
module tb_seg7_mux_display;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        pending;
    logic        frame_tick;

    seg7_mux_display #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .seg        (seg),
        .dig_en     (dig_en),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [3:0] dig_en;
        logic [6:0] seg;
        logic       pending;
        logic       frame_tick;
    } obs_t;

    obs_t exp_q[$];
    int   cyc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // per-cycle digit enables within a frame, as listed for the scan pattern
    localparam logic [3:0] DIG_TAB [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                                            4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};
    localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // reference state: frame position, shadow, displayed value, pending flag
    int          m_pos    = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_disp   = '0;
    logic        m_pend   = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t expected_now();
        obs_t o;
        int   d;
        logic [15:0] upper;
        d = m_pos / 4;
        o.dig_en     = DIG_TAB[m_pos];
        o.seg        = SEG_TAB[m_disp[4*d +: 4]];
        upper        = m_disp >> (4*d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d > 0 && upper == 16'h0) o.seg = 7'h00;
`endif
        o.pending    = m_pend;
        o.frame_tick = (m_pos == 15);
        return o;
    endfunction

    task automatic step(input logic ld, input logic [15:0] v, input logic rs);
        exp_q.push_back(expected_now());
        cyc_q.push_back(cyc);
        rst_n = rs;
        load  = ld;
        value = v;
        @(posedge clk);
        #1;
        cyc++;
        if (!rs) begin
            m_pos = 0; m_shadow = '0; m_disp = '0; m_pend = 1'b0;
        end else begin
            if (m_pos == 15 && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end
            if (ld) begin
                m_shadow = v;
                m_pend   = 1'b1;
            end
            m_pos = (m_pos + 1) % 16;
        end
    endtask

    task automatic idle_until(input int pos);
        while (m_pos != pos) step(1'b0, 16'h0, 1'b1);
    endtask

    task automatic idle_frames(input int n);
        repeat (16 * n) step(1'b0, 16'h0, 1'b1);
    endtask

    // monitor: outputs are presented every cycle, sampled mid-cycle
    initial begin
        obs_t e, a;
        int   c;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                a = '{dig_en, seg, pending, frame_tick};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got dig_en=%h seg=%h pending=%b frame_tick=%b, want dig_en=%h seg=%h pending=%b frame_tick=%b",
                             c, a.dig_en, a.seg, a.pending, a.frame_tick,
                             e.dig_en, e.seg, e.pending, e.frame_tick);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        @(posedge clk);
        #1;
        // reset state, with a load attempt that must be ignored
        step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        // free-running scan pattern
        idle_frames(2);
        // load 1234 on cycle 2, shown next frame
        idle_until(2);
        step(1'b1, 16'h1234, 1'b1);
        idle_until(0);
        idle_frames(1);
        // load 00AB, then 00CD on the frame_tick cycle
        idle_until(5);
        step(1'b1, 16'h00AB, 1'b1);
        idle_until(15);
        step(1'b1, 16'h00CD, 1'b1);
        idle_frames(2);
        // leading-zero cases
        idle_until(3);
        step(1'b1, 16'h0005, 1'b1);
        idle_until(0);
        idle_frames(1);
        idle_until(1);
        step(1'b1, 16'h0000, 1'b1);
        idle_until(0);
        idle_frames(1);
        // reset mid-frame with a capture waiting
        idle_until(2);
        step(1'b1, 16'h9F00, 1'b1);
        idle_until(7);
        step(1'b0, 16'h0, 1'b0);
        idle_frames(2);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_mux_display.md
SEG7_MUX_DISPLAY -- requirements
Module: seg7_mux_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed hex digits, legal range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 1024: clock cycles per digit slot, legal range >= 2.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: synchronous, active-low reset.
REQ-005 SHALL have port value  input  4*NUM_DIGITS: hex value; nibble i drives digit i, with digit 0 least significant.
REQ-006 SHALL have port load  input  1: capture request for value; one cycle per request.
REQ-007 SHALL have port seg  output  7: segment drive, active-high, seg[0]=a through seg[6]=g.
REQ-008 SHALL have port dig_en  output  NUM_DIGITS: digit enables, active-high, at most one bit set.
REQ-009 SHALL have port pending  output  1: a captured value is waiting for the next frame boundary.
REQ-010 SHALL have port frame_tick  output  1: one-cycle pulse on the last cycle of each frame.

Function
REQ-011 SHALL hold a prescaler presc that counts 0..SCAN_DIV-1 and wraps to 0.
REQ-012 SHALL hold a digit index idx that increments when presc==SCAN_DIV-1 and wraps from NUM_DIGITS-1 to 0.
REQ-013 SHALL capture value into a shadow register and set pending on any cycle with load=1.
REQ-014 SHALL assert frame_tick iff presc==SCAN_DIV-1 and idx==NUM_DIGITS-1; with NUM_DIGITS=1, every slot end is a frame boundary.
REQ-015 SHALL copy shadow into the display register on the clock edge ending a frame_tick cycle when pending=1, then clear pending.
REQ-016 SHALL handle load coinciding with frame_tick as follows: display takes the old shadow content, shadow takes the new value, pending stays 1.
REQ-017 SHALL let a later load before a frame boundary overwrite shadow, so only the last value is displayed and no request is queued.
REQ-018 SHALL drive dig_en[i]=1 iff idx==i and presc!=0; the presc==0 cycle is an all-off anti-ghosting gap.
REQ-019 SHALL drive seg as the hex decode of display nibble idx: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-020 SHALL derive seg, dig_en, pending and frame_tick from registered state only, with no combinational path from value or load.
REQ-021 SHALL make frame period exactly NUM_DIGITS*SCAN_DIV cycles.
REQ-022 SHALL make the display update latency from load at most NUM_DIGITS*SCAN_DIV cycles, and never split a frame.

Reset
REQ-023 SHALL clear presc, idx, shadow, display and pending on a clock edge with rst_n=0, including mid-frame; a pending capture is discarded.
REQ-024 SHALL give outputs these values during and after reset until the first count: dig_en=0, seg=3F (digit 0 shows 0), pending=0, frame_tick=0.
REQ-025 SHALL ignore load while rst_n=0.

Configuration
REQ-026 SHALL implement leading-zero blanking when macro SEG7_LEADING_ZERO_BLANK_EN is defined: seg=00 for digit i>0 when display nibbles i..NUM_DIGITS-1 are all zero.
REQ-027 SHALL never blank digit 0 under SEG7_LEADING_ZERO_BLANK_EN, and SHALL leave dig_en timing unchanged by blanking.
REQ-028 SHALL decode every digit per REQ-019 with no blanking when SEG7_LEADING_ZERO_BLANK_EN is undefined.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-029 SHALL cover scan timing: after reset, free run -> dig_en per cycle 0,1,1,1,0,2,2,2,0,4,4,4,0,8,8,8 (hex), repeating; frame_tick high on cycle 15 only.
REQ-030 SHALL cover load to display: load value=1234 on cycle 2 -> pending=1 until the edge after cycle 15; in the next frame digit0 seg=66, digit1 4F, digit2 5B, digit3 06.
REQ-031 SHALL cover simultaneous events: load 00AB, then load 00CD on the frame_tick cycle -> next frame shows A,B digits (77,7C); pending=1; the following frame shows C,D (39,5E).
REQ-032 SHALL cover leading-zero blanking: load 0005 -> with SEG7_LEADING_ZERO_BLANK_EN, digits 3..1 seg=00 and digit0 6D; without it, digits 3..1 show 3F; load 0000 with macro -> digit0 3F.
REQ-033 SHALL cover reset mid-operation: load 9F00 and pulse rst_n low on cycle 7 before the frame boundary -> pending=0, dig_en=0, seg=3F, and the next frames show 0000.
